// File: rtl/axi_arb_2x1_pkg.sv
// Shared widths, field offsets and FSM encodings for the 2x1 AXI arbiter.
// AR/AW packing (MSB..LSB): {id, addr, len, size, burst, lock, cache, prot}.
// W packing (MSB..LSB): {wid, wdata, wstrb, wlast}, wlast is bit 0.
package axi_arb_2x1_pkg;

  localparam int unsigned ID_W    = 4;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned LOCK_W  = 2;
  localparam int unsigned CACHE_W = 4;
  localparam int unsigned PROT_W  = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = DATA_W / 8;

  localparam int unsigned PROT_LSB  = 0;
  localparam int unsigned CACHE_LSB = PROT_LSB + PROT_W;
  localparam int unsigned LOCK_LSB  = CACHE_LSB + CACHE_W;
  localparam int unsigned BURST_LSB = LOCK_LSB + LOCK_W;
  localparam int unsigned SIZE_LSB  = BURST_LSB + BURST_W;
  localparam int unsigned LEN_LSB   = SIZE_LSB + SIZE_W;
  localparam int unsigned ADDR_LSB  = LEN_LSB + LEN_W;
  localparam int unsigned ID_LSB    = ADDR_LSB + ADDR_W;
  localparam int unsigned AR_W      = ID_LSB + ID_W;
  localparam int unsigned AW_W      = AR_W;

  localparam int unsigned WLAST_BIT = 0;
  localparam int unsigned WSTRB_LSB = WLAST_BIT + 1;
  localparam int unsigned WDATA_LSB = WSTRB_LSB + STRB_W;
  localparam int unsigned WID_LSB   = WDATA_LSB + DATA_W;
  localparam int unsigned W_W       = WID_LSB + ID_W;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_XFER,
    W_RESP
  } wr_state_e;

  function automatic logic w_is_last(input logic [W_W-1:0] w);
    return w[WLAST_BIT];
  endfunction

  function automatic logic [ADDR_W-1:0] ax_addr(input logic [AR_W-1:0] ax);
    return ax[ADDR_LSB +: ADDR_W];
  endfunction

  function automatic logic [LEN_W-1:0] ax_len(input logic [AR_W-1:0] ax);
    return ax[LEN_LSB +: LEN_W];
  endfunction

endpackage

// File: rtl/axi_arb_rr2.sv
// Two-way round-robin arbiter: registered grant plus a priority flop that
// points at the master which did not win the most recent completed transfer.
module axi_arb_rr2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       arb,
  input  logic       done,
  output logic       grant
);

  logic prio;
  logic pick;

  // Lone requester wins outright; a tie goes to the priority holder.
  always_comb begin
    pick = prio;
    unique case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      default: pick = prio;
    endcase
  end

  // Grant is latched when the owning FSM is idle and someone is asking.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant <= 1'b0;
    end else if (arb && (|req)) begin
      grant <= pick;
    end
  end

  // Completion hands priority to the master that was not just served.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prio <= 1'b0;
    end else if (done) begin
      prio <= ~grant;
    end
  end

endmodule

// File: rtl/axi_arb_2x1.sv
// Two-master to one-slave AXI arbiter. Independent read and write arbiters,
// one outstanding transaction per direction, payloads muxed by the locked grant.
module axi_arb_2x1
  import axi_arb_2x1_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [2*AR_W-1:0] s_ar,
  input  logic [1:0]        s_arvalid,
  output logic [1:0]        s_arready,
  output logic [1:0]        s_rvalid,
  input  logic [1:0]        s_rready,
  input  logic [2*AW_W-1:0] s_aw,
  input  logic [1:0]        s_awvalid,
  output logic [1:0]        s_awready,
  input  logic [2*W_W-1:0]  s_w,
  input  logic [1:0]        s_wvalid,
  output logic [1:0]        s_wready,
  output logic [1:0]        s_bvalid,
  input  logic [1:0]        s_bready,
  output logic [AR_W-1:0]   m_ar,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic              m_rlast,
  output logic              m_rready,
  output logic [AW_W-1:0]   m_aw,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [W_W-1:0]    m_w,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic              m_bvalid,
  output logic              m_bready
);

  // ---------------- read path ----------------
  rd_state_e rd_state;
  rd_state_e rd_state_nxt;
  logic      rd_grant;
  logic      rd_arb;
  logic      rd_ar_hs;
  logic      rd_r_hs;
  logic      rd_done;

  assign rd_arb   = (rd_state == R_IDLE);
  assign rd_ar_hs = (rd_state == R_ADDR) && s_arvalid[rd_grant] && m_arready;
  assign rd_r_hs  = (rd_state == R_DATA) && m_rvalid && s_rready[rd_grant];
  assign rd_done  = rd_r_hs && m_rlast;

  axi_arb_rr2 u_rd_rr (
    .clk    (clk),
    .resetn (resetn),
    .req    (s_arvalid),
    .arb    (rd_arb),
    .done   (rd_done),
    .grant  (rd_grant)
  );

  // Read state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state <= R_IDLE;
    end else begin
      rd_state <= rd_state_nxt;
    end
  end

  // Read next state: idle waits one cycle for the grant to register.
  always_comb begin
    rd_state_nxt = rd_state;
    unique case (rd_state)
      R_IDLE:  if (|s_arvalid) rd_state_nxt = R_ADDR;
      R_ADDR:  if (rd_ar_hs)   rd_state_nxt = R_DATA;
      R_DATA:  if (rd_done)    rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // Read outputs: only the granted master's valid/ready is ever connected.
  always_comb begin
    m_ar      = rd_grant ? s_ar[2*AR_W-1:AR_W] : s_ar[AR_W-1:0];
    m_arvalid = 1'b0;
    s_arready = '0;
    m_rready  = 1'b0;
    s_rvalid  = '0;
    unique case (rd_state)
      R_ADDR: begin
        m_arvalid           = s_arvalid[rd_grant];
        s_arready[rd_grant] = m_arready;
      end
      R_DATA: begin
        m_rready           = s_rready[rd_grant];
        s_rvalid[rd_grant] = m_rvalid;
      end
      default: ;
    endcase
  end

  // ---------------- write path ----------------
  wr_state_e      wr_state;
  wr_state_e      wr_state_nxt;
  logic           wr_grant;
  logic           wr_arb;
  logic           aw_done;
  logic           w_done;
  logic           wr_aw_hs;
  logic           wr_w_hs;
  logic           wr_wlast_hs;
  logic           wr_xfer_done;
  logic           wr_done;
  logic [W_W-1:0] w_sel;

  assign w_sel        = wr_grant ? s_w[2*W_W-1:W_W] : s_w[W_W-1:0];
  assign wr_arb       = (wr_state == W_IDLE);
  assign wr_aw_hs     = (wr_state == W_XFER) && !aw_done && s_awvalid[wr_grant] && m_awready;
  assign wr_w_hs      = (wr_state == W_XFER) && !w_done && s_wvalid[wr_grant] && m_wready;
  assign wr_wlast_hs  = wr_w_hs && w_is_last(w_sel);
  // Either half may finish in the same cycle as the other.
  assign wr_xfer_done = (aw_done || wr_aw_hs) && (w_done || wr_wlast_hs);
  assign wr_done      = (wr_state == W_RESP) && m_bvalid && s_bready[wr_grant];

  axi_arb_rr2 u_wr_rr (
    .clk    (clk),
    .resetn (resetn),
    .req    (s_awvalid),
    .arb    (wr_arb),
    .done   (wr_done),
    .grant  (wr_grant)
  );

  // Write state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_state <= W_IDLE;
    end else begin
      wr_state <= wr_state_nxt;
    end
  end

  // AW/W completion flags, live only while transferring.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (wr_state != W_XFER) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      aw_done <= aw_done || wr_aw_hs;
      w_done  <= w_done || wr_wlast_hs;
    end
  end

  // Write next state: arbitrate on AW only, respond once AW and last W are in.
  always_comb begin
    wr_state_nxt = wr_state;
    unique case (wr_state)
      W_IDLE:  if (|s_awvalid)   wr_state_nxt = W_XFER;
      W_XFER:  if (wr_xfer_done) wr_state_nxt = W_RESP;
      W_RESP:  if (wr_done)      wr_state_nxt = W_IDLE;
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  // Write outputs: AW and W forwarded independently for the granted master.
  always_comb begin
    m_aw      = wr_grant ? s_aw[2*AW_W-1:AW_W] : s_aw[AW_W-1:0];
    m_w       = w_sel;
    m_awvalid = 1'b0;
    s_awready = '0;
    m_wvalid  = 1'b0;
    s_wready  = '0;
    m_bready  = 1'b0;
    s_bvalid  = '0;
    unique case (wr_state)
      W_XFER: begin
        m_awvalid           = s_awvalid[wr_grant] && !aw_done;
        s_awready[wr_grant] = m_awready && !aw_done;
        m_wvalid            = s_wvalid[wr_grant] && !w_done;
        s_wready[wr_grant]  = m_wready && !w_done;
      end
      W_RESP: begin
        m_bready           = s_bready[wr_grant];
        s_bvalid[wr_grant] = m_bvalid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_arb_2x1.sv
// Self-checking bench for axi_arb_2x1: TB-side masters and bridge with random
// handshake timing, checked against a transaction-level arbitration model.
module tb_axi_arb_2x1;
  import axi_arb_2x1_pkg::*;

  logic              clk = 1'b0;
  logic              resetn;
  logic [2*AR_W-1:0] s_ar;
  logic [1:0]        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [2*AW_W-1:0] s_aw;
  logic [1:0]        s_awvalid, s_awready;
  logic [2*W_W-1:0]  s_w;
  logic [1:0]        s_wvalid, s_wready, s_bvalid, s_bready;
  logic [AR_W-1:0]   m_ar;
  logic              m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [AW_W-1:0]   m_aw;
  logic              m_awvalid, m_awready;
  logic [W_W-1:0]    m_w;
  logic              m_wvalid, m_wready, m_bvalid, m_bready;

  always #5 clk = ~clk;

  axi_arb_2x1 dut (
    .clk(clk), .resetn(resetn),
    .s_ar(s_ar), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_aw(s_aw), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_w(s_w), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_ar(m_ar), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready),
    .m_aw(m_aw), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_w(m_w), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    int unsigned dly;
    int unsigned wdly;
  } txn_t;

  txn_t rq [2][$];
  txn_t wq [2][$];

  logic [AR_W-1:0] ar_pay [2];
  logic [AW_W-1:0] aw_pay [2];
  logic [W_W-1:0]  w_pay  [2];
  assign s_ar = {ar_pay[1], ar_pay[0]};
  assign s_aw = {aw_pay[1], aw_pay[0]};
  assign s_w  = {w_pay[1], w_pay[0]};

  // TB master state
  int unsigned mr_st [2], mr_wait [2], rx_cnt [2], rd_cmpl [2];
  int unsigned mw_st [2], mw_wait [2], mw_wleft [2], mw_wdly [2], wr_cmpl [2];
  // TB bridge state
  int unsigned br_rleft;
  logic        br_aw, br_wl;
  logic [31:0] ar_log [$];
  logic [31:0] aw_log [$];
  // Reference model of both arbiters
  logic rd_busy, rd_o, rd_last, rd_ad;
  logic wr_busy, wr_o, wr_last, wr_awd, wr_wd;
  logic overlap_seen;
  // Handshakes sampled at negedge
  logic            ar_hs, r_hs, aw_hs, w_hs, b_hs, cap_rlast;
  logic [AR_W-1:0] cap_ar;
  logic [AW_W-1:0] cap_aw;
  logic [W_W-1:0]  cap_w;
  logic [1:0]      s_ar_hs, s_r_hs, s_aw_hs, s_w_hs, s_b_hs;

  function automatic logic [AR_W-1:0] mk_ax(input int unsigned id, input logic [31:0] addr,
                                            input logic [3:0] len);
    return {4'(id), addr, len, 3'd2, 2'b01, 2'b00, 4'b0000, 3'b000};
  endfunction

  // Lone requester wins; on a tie the master not served last time wins.
  function automatic logic pick(input logic [1:0] req, input logic last);
    if (req == 2'b01) return 1'b0;
    if (req == 2'b10) return 1'b1;
    return ~last;
  endfunction

  function automatic logic all_idle();
    return rq[0].size() == 0 && rq[1].size() == 0 && wq[0].size() == 0 && wq[1].size() == 0 &&
           mr_st[0] == 0 && mr_st[1] == 0 && mw_st[0] == 0 && mw_st[1] == 0 &&
           !rd_busy && !wr_busy;
  endfunction

  task automatic clear_tb();
    for (int i = 0; i < 2; i++) begin
      rq[i].delete(); wq[i].delete();
      mr_st[i] = 0; mr_wait[i] = 0; mw_st[i] = 0; mw_wait[i] = 0;
      mw_wleft[i] = 0; mw_wdly[i] = 0;
    end
    s_arvalid = '0; s_awvalid = '0; s_wvalid = '0; s_rready = '0; s_bready = '0;
    m_arready = 0; m_rvalid = 0; m_rlast = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
    br_rleft = 0; br_aw = 0; br_wl = 0;
    rd_busy = 0; rd_last = 1; rd_ad = 0; rd_o = 0;
    wr_busy = 0; wr_last = 1; wr_awd = 0; wr_wd = 0; wr_o = 0;
  endtask

  // Assert reset mid-cycle, check outputs collapse immediately, then release.
  task automatic do_reset(input string tag);
    resetn = 1'b0;
    #1;
    check({tag, " valids/readies"},
          {s_arready, s_rvalid, s_awready, s_wready, s_bvalid,
           m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}, '0);
    check({tag, " m_ar slice0"}, m_ar, ar_pay[0]);
    check({tag, " m_aw slice0"}, m_aw, aw_pay[0]);
    check({tag, " m_w slice0"}, m_w, w_pay[0]);
    clear_tb();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic step();
    logic [1:0] ohr, ohw;
    @(negedge clk);
    ohr = rd_o ? 2'b10 : 2'b01;
    ohw = wr_o ? 2'b10 : 2'b01;
    // read channel routing
    if (rd_busy && !rd_ad) begin
      check("m_arvalid", m_arvalid, s_arvalid[rd_o]);
      check("s_arready", s_arready, m_arready ? ohr : 2'b00);
      check("m_ar", m_ar, ar_pay[rd_o]);
    end else begin
      check("m_arvalid quiet", m_arvalid, 0);
      check("s_arready quiet", s_arready, 0);
    end
    if (rd_busy && rd_ad) begin
      check("m_rready", m_rready, s_rready[rd_o]);
      check("s_rvalid", s_rvalid, m_rvalid ? ohr : 2'b00);
    end else begin
      check("m_rready quiet", m_rready, 0);
      check("s_rvalid quiet", s_rvalid, 0);
    end
    // write channel routing
    if (wr_busy && !(wr_awd && wr_wd)) begin
      check("m_awvalid", m_awvalid, !wr_awd && s_awvalid[wr_o]);
      check("s_awready", s_awready, (!wr_awd && m_awready) ? ohw : 2'b00);
      check("m_wvalid", m_wvalid, !wr_wd && s_wvalid[wr_o]);
      check("s_wready", s_wready, (!wr_wd && m_wready) ? ohw : 2'b00);
      if (!wr_awd && s_awvalid[wr_o]) check("m_aw", m_aw, aw_pay[wr_o]);
      if (!wr_wd && s_wvalid[wr_o]) check("m_w", m_w, w_pay[wr_o]);
    end else begin
      check("m_awvalid quiet", m_awvalid, 0);
      check("s_awready quiet", s_awready, 0);
      check("m_wvalid quiet", m_wvalid, 0);
      check("s_wready quiet", s_wready, 0);
    end
    if (wr_busy && wr_awd && wr_wd) begin
      check("m_bready", m_bready, s_bready[wr_o]);
      check("s_bvalid", s_bvalid, m_bvalid ? ohw : 2'b00);
    end else begin
      check("m_bready quiet", m_bready, 0);
      check("s_bvalid quiet", s_bvalid, 0);
    end
    if (rd_busy && wr_busy && rd_o != wr_o) overlap_seen = 1'b1;
    // sample handshakes as they will occur at the coming edge
    ar_hs = m_arvalid & m_arready;  cap_ar = m_ar;
    r_hs  = m_rvalid & m_rready;    cap_rlast = m_rlast;
    aw_hs = m_awvalid & m_awready;  cap_aw = m_aw;
    w_hs  = m_wvalid & m_wready;    cap_w = m_w;
    b_hs  = m_bvalid & m_bready;
    s_ar_hs = s_arvalid & s_arready; s_r_hs = s_rvalid & s_rready;
    s_aw_hs = s_awvalid & s_awready; s_w_hs = s_wvalid & s_wready;
    s_b_hs  = s_bvalid & s_bready;
    // advance the reference model
    if (!rd_busy) begin
      if (|s_arvalid) begin rd_o = pick(s_arvalid, rd_last); rd_busy = 1; rd_ad = 0; end
    end else if (!rd_ad) begin
      if (s_arvalid[rd_o] && m_arready) rd_ad = 1;
    end else if (m_rvalid && s_rready[rd_o] && m_rlast) begin
      rd_busy = 0; rd_last = rd_o;
    end
    if (!wr_busy) begin
      if (|s_awvalid) begin
        wr_o = pick(s_awvalid, wr_last); wr_busy = 1; wr_awd = 0; wr_wd = 0;
      end
    end else if (!(wr_awd && wr_wd)) begin
      if (!wr_awd && s_awvalid[wr_o] && m_awready) wr_awd = 1;
      if (!wr_wd && s_wvalid[wr_o] && m_wready && w_pay[wr_o][WLAST_BIT]) wr_wd = 1;
    end else if (m_bvalid && s_bready[wr_o]) begin
      wr_busy = 0; wr_last = wr_o;
    end

    @(posedge clk);
    #1;
    // bridge: read side
    if (ar_hs) begin
      br_rleft = int'(ax_len(cap_ar)) + 1;
      ar_log.push_back(ax_addr(cap_ar));
    end
    if (r_hs) br_rleft--;
    if (!m_rvalid || r_hs) m_rvalid = (br_rleft > 0) && ($urandom_range(0, 3) != 0);
    m_rlast   = (br_rleft == 1);
    m_arready = ($urandom_range(0, 2) != 0);
    // bridge: write side
    if (b_hs) begin m_bvalid = 0; br_aw = 0; br_wl = 0; end
    if (aw_hs) begin br_aw = 1; aw_log.push_back(ax_addr(cap_aw)); end
    if (w_hs && cap_w[WLAST_BIT]) br_wl = 1;
    if (!m_bvalid && br_aw && br_wl && $urandom_range(0, 1) == 1) m_bvalid = 1;
    m_awready = ($urandom_range(0, 2) != 0);
    m_wready  = ($urandom_range(0, 2) != 0);
    // masters
    for (int i = 0; i < 2; i++) begin
      txn_t t;
      if (s_r_hs[i]) begin
        rx_cnt[i]++;
        if (cap_rlast) begin mr_st[i] = 0; rd_cmpl[i]++; end
      end
      if (s_ar_hs[i]) begin s_arvalid[i] = 0; mr_st[i] = 2; end
      if (mr_st[i] == 0 && rq[i].size() > 0) begin
        if (mr_wait[i] < rq[i][0].dly) mr_wait[i]++;
        else begin
          t = rq[i].pop_front();
          ar_pay[i] = mk_ax(i, t.addr, t.len);
          s_arvalid[i] = 1; mr_st[i] = 1; mr_wait[i] = 0;
        end
      end
      s_rready[i] = ($urandom_range(0, 3) != 0);

      if (s_aw_hs[i]) s_awvalid[i] = 0;
      if (s_w_hs[i]) begin mw_wleft[i]--; s_wvalid[i] = 0; end
      if (s_b_hs[i]) begin mw_st[i] = 0; wr_cmpl[i]++; end
      if (mw_st[i] == 0 && wq[i].size() > 0) begin
        if (mw_wait[i] < wq[i][0].dly) mw_wait[i]++;
        else begin
          t = wq[i].pop_front();
          aw_pay[i] = mk_ax(i, t.addr, t.len);
          s_awvalid[i] = 1; mw_wleft[i] = int'(t.len) + 1; mw_wdly[i] = t.wdly;
          mw_st[i] = 1; mw_wait[i] = 0;
        end
      end else if (mw_st[i] == 1 && mw_wleft[i] > 0 && !s_wvalid[i]) begin
        if (mw_wdly[i] > 0) mw_wdly[i]--;
        else begin
          w_pay[i] = {4'(i), 32'($urandom), 4'hf, 1'(mw_wleft[i] == 1)};
          s_wvalid[i] = 1;
        end
      end
      s_bready[i] = ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic run(input int unsigned budget, input string tag);
    int unsigned n = 0;
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    check({tag, " completed in budget"}, all_idle(), 1'b1);
  endtask

  initial begin
    int unsigned rd0, rd1, wr0, wr1, exp_rx0, exp_rx1, b0, b1;
    logic [31:0] exp_order [4];
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ar_pay[i] = mk_ax(i, 32'($urandom), 4'd5);
      aw_pay[i] = mk_ax(i, 32'($urandom), 4'd2);
      w_pay[i]  = {4'(i), 32'($urandom), 4'hf, 1'b0};
      rx_cnt[i] = 0; rd_cmpl[i] = 0; wr_cmpl[i] = 0;
    end
    clear_tb();
    overlap_seen = 0;
    @(posedge clk);
    #1;
    do_reset("reset");

    // M0 alone: 4-beat read at 0x100
    ar_log.delete();
    rq[0].push_back('{addr: 32'h100, len: 4'd3, dly: 0, wdly: 0});
    run(300, "m0 read");
    check("m0 read beats", rx_cnt[0], 4);
    check("m1 no beats", rx_cnt[1], 0);
    check("m0 read addr", ar_log[0], 32'h100);
    check("m0 read count", ar_log.size(), 1);

    // Both requesting continuously after reset: M0,M1,M0,M1
    do_reset("reset2");
    ar_log.delete();
    rq[0].push_back('{addr: 32'h1000, len: 4'd0, dly: 0, wdly: 0});
    rq[0].push_back('{addr: 32'h1004, len: 4'd0, dly: 0, wdly: 0});
    rq[1].push_back('{addr: 32'h2000, len: 4'd0, dly: 0, wdly: 0});
    rq[1].push_back('{addr: 32'h2004, len: 4'd0, dly: 0, wdly: 0});
    run(400, "rr reads");
    exp_order = '{32'h1000, 32'h2000, 32'h1004, 32'h2004};
    for (int k = 0; k < 4; k++) check($sformatf("rr order %0d", k), ar_log[k], exp_order[k]);

    // M1 write with delayed W beats, M0 AW arriving a cycle later waits
    do_reset("reset3");
    aw_log.delete();
    wr0 = wr_cmpl[0]; wr1 = wr_cmpl[1];
    wq[1].push_back('{addr: 32'h3000, len: 4'd1, dly: 0, wdly: 2});
    wq[0].push_back('{addr: 32'h3100, len: 4'd0, dly: 1, wdly: 0});
    run(400, "writes");
    check("m1 write done", wr_cmpl[1] - wr1, 1);
    check("m0 write done", wr_cmpl[0] - wr0, 1);
    check("aw order 0", aw_log[0], 32'h3000);
    check("aw order 1", aw_log[1], 32'h3100);

    // Concurrent M0 read and M1 write
    overlap_seen = 0;
    rd0 = rd_cmpl[0]; wr1 = wr_cmpl[1]; b0 = rx_cnt[0];
    rq[0].push_back('{addr: 32'h4000, len: 4'd7, dly: 0, wdly: 0});
    wq[1].push_back('{addr: 32'h5000, len: 4'd0, dly: 0, wdly: 1});
    run(400, "concurrent");
    check("conc read done", rd_cmpl[0] - rd0, 1);
    check("conc read beats", rx_cnt[0] - b0, 8);
    check("conc write done", wr_cmpl[1] - wr1, 1);
    check("conc overlap", overlap_seen, 1'b1);

    // Random traffic on both masters and both directions
    rd0 = rd_cmpl[0]; rd1 = rd_cmpl[1]; wr0 = wr_cmpl[0]; wr1 = wr_cmpl[1];
    b0 = rx_cnt[0]; b1 = rx_cnt[1]; exp_rx0 = 0; exp_rx1 = 0;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 2; i++) begin
        txn_t t;
        t.addr = 32'($urandom) & 32'hffff_fffc;
        t.len  = 4'($urandom_range(0, 7));
        t.dly  = $urandom_range(0, 3);
        t.wdly = $urandom_range(0, 3);
        rq[i].push_back(t);
        if (i == 0) exp_rx0 += int'(t.len) + 1; else exp_rx1 += int'(t.len) + 1;
        t.addr = 32'($urandom) & 32'hffff_fffc;
        t.len  = 4'($urandom_range(0, 7));
        wq[i].push_back(t);
      end
    end
    run(8000, "random");
    check("rand m0 reads", rd_cmpl[0] - rd0, 12);
    check("rand m1 reads", rd_cmpl[1] - rd1, 12);
    check("rand m0 beats", rx_cnt[0] - b0, exp_rx0);
    check("rand m1 beats", rx_cnt[1] - b1, exp_rx1);
    check("rand m0 writes", wr_cmpl[0] - wr0, 12);
    check("rand m1 writes", wr_cmpl[1] - wr1, 12);

    // Reset in the middle of a read burst, then tie goes to M0
    do_reset("reset4");
    b0 = rx_cnt[0];
    rq[0].push_back('{addr: 32'h6000, len: 4'd7, dly: 0, wdly: 0});
    for (int n = 0; n < 300 && (rx_cnt[0] - b0) < 2; n++) step();
    check("midburst reached beat 2", rx_cnt[0] - b0, 2);
    check("midburst in data phase", rd_busy && rd_ad, 1'b1);
    do_reset("midburst reset");
    ar_log.delete();
    rq[0].push_back('{addr: 32'h7000, len: 4'd0, dly: 0, wdly: 0});
    rq[1].push_back('{addr: 32'h8000, len: 4'd0, dly: 0, wdly: 0});
    run(300, "post reset");
    check("post reset first", ar_log[0], 32'h7000);
    check("post reset second", ar_log[1], 32'h8000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
